// File: rtl/rename_map_ckpt_pkg.sv
// Shared defaults and transaction types for the checkpointed rename map.
package rename_map_ckpt_pkg;

  localparam int unsigned NR_ARCH_REGS_DEF    = 32;
  localparam int unsigned NR_PHYS_REGS_DEF    = 64;
  localparam int unsigned NR_COMMIT_PORTS_DEF = 2;
  localparam int unsigned ARCH_W_DEF          = $clog2(NR_ARCH_REGS_DEF);
  localparam int unsigned PHYS_W_DEF          = $clog2(NR_PHYS_REGS_DEF);

  typedef struct packed {
    logic [ARCH_W_DEF-1:0] rs1;
    logic [ARCH_W_DEF-1:0] rs2;
    logic [ARCH_W_DEF-1:0] rd;
    logic                  we;
  } rn_req_t;

  typedef struct packed {
    logic [PHYS_W_DEF-1:0] prs1;
    logic [PHYS_W_DEF-1:0] prs2;
    logic [PHYS_W_DEF-1:0] prd;
    logic [PHYS_W_DEF-1:0] prev_prd;
  } rn_rsp_t;

  typedef struct packed {
    logic                  valid;
    logic [ARCH_W_DEF-1:0] rd;
    logic [PHYS_W_DEF-1:0] prd;
    logic [PHYS_W_DEF-1:0] prev_prd;
  } cm_port_t;

endpackage

// File: rtl/rename_map_ckpt_chk.sv
// Protocol checks on the commit ports of the rename map.
module rename_map_ckpt_chk #(
  parameter int unsigned NR_PHYS_REGS    = 64,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned ARCH_W          = 5,
  parameter int unsigned PHYS_W          = 6
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NR_COMMIT_PORTS-1:0]        i_cm_valid,
  input  logic [NR_COMMIT_PORTS*ARCH_W-1:0] i_cm_rd,
  input  logic [NR_COMMIT_PORTS*PHYS_W-1:0] i_cm_prd,
  input  logic [NR_COMMIT_PORTS*PHYS_W-1:0] i_cm_prev_prd,
  input  logic [NR_PHYS_REGS-1:0]           i_spec_busy
);

  for (genvar k = 0; k < NR_COMMIT_PORTS; k++) begin : g_port
    logic [ARCH_W-1:0] w_rd;
    logic [PHYS_W-1:0] w_prd;
    logic [PHYS_W-1:0] w_prev;
    assign w_rd   = i_cm_rd[k*ARCH_W +: ARCH_W];
    assign w_prd  = i_cm_prd[k*PHYS_W +: PHYS_W];
    assign w_prev = i_cm_prev_prd[k*PHYS_W +: PHYS_W];

    a_prev_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_cm_valid[k] && (|w_rd) && (|w_prev)) |-> i_spec_busy[w_prev]);

    a_prd_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_cm_valid[k] && (|w_rd)) |-> i_spec_busy[w_prd]);
  end

endmodule

// File: rtl/rename_map_ckpt_free_picker.sv
// Lowest-free finder over the speculative busy vector.
module rename_map_ckpt_free_picker #(
  parameter int unsigned N = 64,
  parameter int unsigned W = 6
) (
  input  logic [N-1:0] i_busy,
  output logic [W-1:0] o_idx,
  output logic         o_empty
);

  // Scan downwards so the lowest free index is the last one written.
  always_comb begin
    o_idx = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      o_idx = i_busy[i] ? o_idx : W'(i);
    end
  end

  assign o_empty = &i_busy;

endmodule

// File: rtl/rename_map_ckpt.sv
// Register rename map with a committed checkpoint: one rename per cycle,
// NR_COMMIT_PORTS commits per cycle, single-cycle flush back to the committed state.
module rename_map_ckpt
  import rename_map_ckpt_pkg::*;
#(
  parameter int unsigned NR_ARCH_REGS    = NR_ARCH_REGS_DEF,
  parameter int unsigned NR_PHYS_REGS    = NR_PHYS_REGS_DEF,
  parameter int unsigned NR_COMMIT_PORTS = NR_COMMIT_PORTS_DEF,
  parameter int unsigned ARCH_W          = $clog2(NR_ARCH_REGS),
  parameter int unsigned PHYS_W          = $clog2(NR_PHYS_REGS)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              rn_valid_i,
  output logic                              rn_ready_o,
  input  logic [ARCH_W-1:0]                 rn_rs1_i,
  input  logic [ARCH_W-1:0]                 rn_rs2_i,
  input  logic [ARCH_W-1:0]                 rn_rd_i,
  input  logic                              rn_we_i,
  output logic                              rn_valid_o,
  output logic [PHYS_W-1:0]                 rn_prs1_o,
  output logic [PHYS_W-1:0]                 rn_prs2_o,
  output logic [PHYS_W-1:0]                 rn_prd_o,
  output logic [PHYS_W-1:0]                 rn_prev_prd_o,
  input  logic [NR_COMMIT_PORTS-1:0]        cm_valid_i,
  input  logic [NR_COMMIT_PORTS*ARCH_W-1:0] cm_rd_i,
  input  logic [NR_COMMIT_PORTS*PHYS_W-1:0] cm_prd_i,
  input  logic [NR_COMMIT_PORTS*PHYS_W-1:0] cm_prev_prd_i,
  input  logic                              flush_i,
  output logic [PHYS_W:0]                   free_cnt_o
);

  localparam logic [NR_PHYS_REGS-1:0] PHYS_ONE = {{(NR_PHYS_REGS-1){1'b0}}, 1'b1};
  // Architectural registers start out owning p0..p(NR_ARCH_REGS-1).
  localparam logic [NR_PHYS_REGS-1:0] BUSY_RST = (PHYS_ONE << NR_ARCH_REGS) - PHYS_ONE;
  localparam logic [PHYS_W:0]         FREE_RST = (PHYS_W+1)'(NR_PHYS_REGS - NR_ARCH_REGS);

  logic [PHYS_W-1:0]       r_spec_map [NR_ARCH_REGS];
  logic [PHYS_W-1:0]       r_arch_map [NR_ARCH_REGS];
  logic [NR_PHYS_REGS-1:0] r_spec_busy;
  logic [NR_PHYS_REGS-1:0] r_arch_busy;
  logic [PHYS_W:0]         r_free_cnt;
  logic                    r_rn_valid;
  logic [PHYS_W-1:0]       r_prs1;
  logic [PHYS_W-1:0]       r_prs2;
  logic [PHYS_W-1:0]       r_prd;
  logic [PHYS_W-1:0]       r_prev_prd;

  logic [PHYS_W-1:0]       w_spec_map_nx [NR_ARCH_REGS];
  logic [PHYS_W-1:0]       w_arch_map_nx [NR_ARCH_REGS];
  logic [NR_PHYS_REGS-1:0] w_spec_busy_nx;
  logic [NR_PHYS_REGS-1:0] w_arch_busy_nx;
  logic [PHYS_W:0]         w_free_cnt_nx;
  logic [PHYS_W-1:0]       w_pick_idx;
  logic                    w_pick_empty;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_alloc;

  rename_map_ckpt_free_picker #(
    .N (NR_PHYS_REGS),
    .W (PHYS_W)
  ) u_picker (
    .i_busy  (r_spec_busy),
    .o_idx   (w_pick_idx),
    .o_empty (w_pick_empty)
  );

  rename_map_ckpt_chk #(
    .NR_PHYS_REGS    (NR_PHYS_REGS),
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .ARCH_W          (ARCH_W),
    .PHYS_W          (PHYS_W)
  ) u_chk (
    .i_clk         (clk_i),
    .i_rst_n       (rst_ni),
    .i_cm_valid    (cm_valid_i),
    .i_cm_rd       (cm_rd_i),
    .i_cm_prd      (cm_prd_i),
    .i_cm_prev_prd (cm_prev_prd_i),
    .i_spec_busy   (r_spec_busy)
  );

  // The picker reads the registered busy vector, so a register released this cycle is not reused until the next.
  assign w_ready  = (|r_free_cnt) & ~flush_i;
  assign w_accept = rn_valid_i & w_ready;
  assign w_alloc  = w_accept & rn_we_i & (|rn_rd_i) & ~w_pick_empty;

  // Commits in port order, then either restore from the committed state or allocate.
  always_comb begin
    logic [ARCH_W-1:0]       w_c_rd;
    logic [PHYS_W-1:0]       w_c_prd;
    logic [PHYS_W-1:0]       w_c_prev;
    logic                    w_c_upd;
    logic [NR_PHYS_REGS-1:0] w_c_set;
    logic [NR_PHYS_REGS-1:0] w_c_clr;
    w_arch_map_nx  = r_arch_map;
    w_spec_map_nx  = r_spec_map;
    w_arch_busy_nx = r_arch_busy;
    w_spec_busy_nx = r_spec_busy;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      w_c_rd   = cm_rd_i[k*ARCH_W +: ARCH_W];
      w_c_prd  = cm_prd_i[k*PHYS_W +: PHYS_W];
      w_c_prev = cm_prev_prd_i[k*PHYS_W +: PHYS_W];
      w_c_upd  = cm_valid_i[k] & (|w_c_rd);
      w_c_set  = {NR_PHYS_REGS{w_c_upd}} & (PHYS_ONE << w_c_prd);
      w_c_clr  = {NR_PHYS_REGS{w_c_upd & (|w_c_prev)}} & (PHYS_ONE << w_c_prev);
      w_arch_map_nx[w_c_rd] = w_c_upd ? w_c_prd : w_arch_map_nx[w_c_rd];
      w_arch_busy_nx        = (w_arch_busy_nx | w_c_set) & ~w_c_clr;
      w_spec_busy_nx        = w_spec_busy_nx & ~w_c_clr;
    end
    if (flush_i) begin
      w_spec_map_nx  = w_arch_map_nx;
      w_spec_busy_nx = w_arch_busy_nx;
    end else begin
      w_spec_busy_nx           = w_spec_busy_nx | ({NR_PHYS_REGS{w_alloc}} & (PHYS_ONE << w_pick_idx));
      w_spec_map_nx[rn_rd_i]   = w_alloc ? w_pick_idx : w_spec_map_nx[rn_rd_i];
    end
  end

  // Free count is kept registered, derived from the next busy vector.
  always_comb begin
    w_free_cnt_nx = {(PHYS_W+1){1'b0}};
    for (int p = 0; p < NR_PHYS_REGS; p++) begin
      w_free_cnt_nx = w_free_cnt_nx + {{PHYS_W{1'b0}}, ~w_spec_busy_nx[p]};
    end
  end

  // Map and busy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ARCH_REGS; i++) begin
        r_spec_map[i] <= PHYS_W'(i);
        r_arch_map[i] <= PHYS_W'(i);
      end
      r_spec_busy <= BUSY_RST;
      r_arch_busy <= BUSY_RST;
      r_free_cnt  <= FREE_RST;
    end else begin
      r_spec_map  <= w_spec_map_nx;
      r_arch_map  <= w_arch_map_nx;
      r_spec_busy <= w_spec_busy_nx;
      r_arch_busy <= w_arch_busy_nx;
      r_free_cnt  <= w_free_cnt_nx;
    end
  end

  // Rename response, looked up in the map as it stood at the start of the accept cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rn_valid <= 1'b0;
      r_prs1     <= {PHYS_W{1'b0}};
      r_prs2     <= {PHYS_W{1'b0}};
      r_prd      <= {PHYS_W{1'b0}};
      r_prev_prd <= {PHYS_W{1'b0}};
    end else begin
      r_rn_valid <= w_accept;
      if (w_accept) begin
        r_prs1     <= r_spec_map[rn_rs1_i];
        r_prs2     <= r_spec_map[rn_rs2_i];
        r_prd      <= w_alloc ? w_pick_idx : {PHYS_W{1'b0}};
        r_prev_prd <= w_alloc ? r_spec_map[rn_rd_i] : {PHYS_W{1'b0}};
      end
    end
  end

  assign rn_ready_o    = w_ready;
  assign rn_valid_o    = r_rn_valid;
  assign rn_prs1_o     = r_prs1;
  assign rn_prs2_o     = r_prs2;
  assign rn_prd_o      = r_prd;
  assign rn_prev_prd_o = r_prev_prd;
  assign free_cnt_o    = r_free_cnt;

endmodule
